// File: rtl/masked_req_scheduler.sv
// Three-requester masked arbiter: fixed or rotating priority, one grant held
// until done or a hold timeout, followed by a one-cycle release gap.
module masked_req_scheduler #(
   parameter int HOLD_MAX = 8,
   parameter int RR       = 0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [2:0] req,
   input  logic       mask_wr,
   input  logic [2:0] mask_in,
   input  logic       done,
   output logic [2:0] grant,
   output logic [1:0] grant_id,
   output logic       busy,
   output logic       err_timeout
);

   typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

   localparam logic [7:0] HOLD_LIM = 8'(HOLD_MAX);

   state_t     state;
   logic [2:0] mask;
   logic [2:0] eligible;
   logic [7:0] hold_cnt;
   logic [1:0] rr_ptr;
   logic       found;
   logic [1:0] pick_id;
   logic [1:0] cand [3];

   function automatic logic [1:0] inc3(input logic [1:0] x);
      return (x == 2'd2) ? 2'd0 : x + 2'd1;
   endfunction

   assign eligible = req & mask;

   // NOTE: every output of this block gets a default first so no latch is inferred.
   always_comb begin
      found   = 1'b0;
      pick_id = 2'd0;
      cand[0] = rr_ptr;
      cand[1] = inc3(rr_ptr);
      cand[2] = inc3(cand[1]);
      if (RR != 0) begin
         for (int k = 0; k < 3; k++) begin
            if (!found && eligible[cand[k]]) begin
               found   = 1'b1;
               pick_id = cand[k];
            end
         end
      end else begin
         casez (eligible)
            3'b??1:  begin found = 1'b1; pick_id = 2'd0; end
            3'b?10:  begin found = 1'b1; pick_id = 2'd1; end
            3'b100:  begin found = 1'b1; pick_id = 2'd2; end
            default: begin found = 1'b0; pick_id = 2'd0; end
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         grant       <= 3'b000;
         grant_id    <= 2'd0;
         busy        <= 1'b0;
         err_timeout <= 1'b0;
         mask        <= 3'b111;
         hold_cnt    <= 8'd0;
         rr_ptr      <= 2'd0;
      end else begin
         if (mask_wr)
            mask <= mask_in;
         case (state)
            IDLE: begin
               if (found) begin
                  state    <= GRANT;
                  grant    <= 3'b001 << pick_id;
                  grant_id <= pick_id;
                  busy     <= 1'b1;
                  hold_cnt <= 8'd0;
                  rr_ptr   <= inc3(pick_id);
               end
            end
            GRANT: begin
               // done wins over the timeout in the last allowed cycle
               if (done) begin
                  state <= RELEASE;
                  grant <= 3'b000;
               end else if (hold_cnt + 8'd1 == HOLD_LIM) begin
                  state       <= RELEASE;
                  grant       <= 3'b000;
                  err_timeout <= 1'b1;
               end else begin
                  hold_cnt <= hold_cnt + 8'd1;
               end
            end
            RELEASE: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state <= IDLE;
               grant <= 3'b000;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_masked_req_scheduler.sv
// Scoreboard bench: two instances (fixed priority with HOLD_MAX=4, rotating
// priority with defaults) share stimulus; expected outputs are queued per cycle.
module tb_masked_req_scheduler;

   typedef struct packed {
      logic       sel;
      logic [6:0] exp;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset;
   logic [2:0] req;
   logic       mask_wr;
   logic [2:0] mask_in;
   logic       done;

   logic [2:0] grant0, grant1;
   logic [1:0] grant_id0, grant_id1;
   logic       busy0, busy1, err0, err1;

   exp_t  exp_q [$];
   string name_q [$];
   int    n_checks = 0;
   int    n_fail   = 0;

   always #5 clk = ~clk;

   masked_req_scheduler #(.HOLD_MAX(4), .RR(0)) dut0 (
      .clk(clk), .reset(reset), .req(req), .mask_wr(mask_wr), .mask_in(mask_in),
      .done(done), .grant(grant0), .grant_id(grant_id0), .busy(busy0),
      .err_timeout(err0)
   );

   masked_req_scheduler #(.HOLD_MAX(8), .RR(1)) dut1 (
      .clk(clk), .reset(reset), .req(req), .mask_wr(mask_wr), .mask_in(mask_in),
      .done(done), .grant(grant1), .grant_id(grant_id1), .busy(busy1),
      .err_timeout(err1)
   );

   task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got grant=%b id=%0d busy=%b err=%b, expected grant=%b id=%0d busy=%b err=%b",
                  name, act[6:4], act[3:2], act[1], act[0], exp[6:4], exp[3:2], exp[1], exp[0]);
      end
   endtask

   // Drive one cycle of inputs; queue what the selected instance must show after the edge.
   task automatic step(input string name, input logic sel, input logic rst,
                       input logic [2:0] r, input logic mw, input logic [2:0] mi,
                       input logic d, input logic [2:0] eg, input logic [1:0] eid,
                       input logic eb, input logic ee);
      exp_t e;
      reset   = rst;
      req     = r;
      mask_wr = mw;
      mask_in = mi;
      done    = d;
      @(posedge clk);
      #1;
      e.sel = sel;
      e.exp = {eg, eid, eb, ee};
      exp_q.push_back(e);
      name_q.push_back(name);
   endtask

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t  e;
         string nm;
         logic [6:0] act;
         e  = exp_q.pop_front();
         nm = name_q.pop_front();
         act = e.sel ? {grant1, grant_id1, busy1, err1} : {grant0, grant_id0, busy0, err0};
         check(nm, act, e.exp);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within the time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      // name, sel, reset, req, mask_wr, mask_in, done, exp grant, id, busy, err
      step("rst0",        0, 1, 3'b111, 0, 3'b000, 1, 3'b000, 2'd0, 0, 0);
      step("rst1",        0, 1, 3'b111, 0, 3'b000, 1, 3'b000, 2'd0, 0, 0);
      step("prio_110",    0, 0, 3'b110, 0, 3'b000, 0, 3'b010, 2'd1, 1, 0);
      step("prio_done",   0, 0, 3'b110, 0, 3'b000, 1, 3'b000, 2'd1, 1, 0);
      step("prio_idle",   0, 0, 3'b000, 0, 3'b000, 0, 3'b000, 2'd1, 0, 0);
      step("mask_wr100",  0, 0, 3'b000, 1, 3'b100, 0, 3'b000, 2'd1, 0, 0);
      step("noact_a",     0, 0, 3'b011, 0, 3'b000, 0, 3'b000, 2'd1, 0, 0);
      step("noact_b",     0, 0, 3'b011, 0, 3'b000, 0, 3'b000, 2'd1, 0, 0);
      step("noact_c",     0, 0, 3'b011, 0, 3'b000, 1, 3'b000, 2'd1, 0, 0);
      step("masked_111",  0, 0, 3'b111, 0, 3'b000, 0, 3'b100, 2'd2, 1, 0);
      step("nopre_mask",  0, 0, 3'b001, 1, 3'b011, 0, 3'b100, 2'd2, 1, 0);
      step("nopre_hold",  0, 0, 3'b001, 0, 3'b000, 0, 3'b100, 2'd2, 1, 0);
      step("nopre_done",  0, 0, 3'b001, 0, 3'b000, 1, 3'b000, 2'd2, 1, 0);
      step("nopre_rel",   0, 0, 3'b001, 0, 3'b000, 0, 3'b000, 2'd2, 0, 0);
      step("nopre_next",  0, 0, 3'b001, 0, 3'b000, 0, 3'b001, 2'd0, 1, 0);
      step("lim_c1",      0, 0, 3'b001, 0, 3'b000, 0, 3'b001, 2'd0, 1, 0);
      step("lim_c2",      0, 0, 3'b001, 0, 3'b000, 0, 3'b001, 2'd0, 1, 0);
      step("lim_c3",      0, 0, 3'b001, 0, 3'b000, 0, 3'b001, 2'd0, 1, 0);
      step("lim_done",    0, 0, 3'b001, 0, 3'b000, 1, 3'b000, 2'd0, 1, 0);
      step("lim_rel",     0, 0, 3'b000, 0, 3'b000, 0, 3'b000, 2'd0, 0, 0);
      step("to_issue",    0, 0, 3'b001, 0, 3'b000, 0, 3'b001, 2'd0, 1, 0);
      step("to_c1",       0, 0, 3'b001, 0, 3'b000, 0, 3'b001, 2'd0, 1, 0);
      step("to_c2",       0, 0, 3'b001, 0, 3'b000, 0, 3'b001, 2'd0, 1, 0);
      step("to_c3",       0, 0, 3'b001, 0, 3'b000, 0, 3'b001, 2'd0, 1, 0);
      step("to_fire",     0, 0, 3'b001, 0, 3'b000, 0, 3'b000, 2'd0, 1, 1);
      step("to_rel",      0, 0, 3'b000, 0, 3'b000, 0, 3'b000, 2'd0, 0, 1);
      step("to_sticky1",  0, 0, 3'b000, 0, 3'b000, 1, 3'b000, 2'd0, 0, 1);
      step("mask_wr010",  0, 0, 3'b000, 1, 3'b010, 0, 3'b000, 2'd0, 0, 1);
      step("rg_issue",    0, 0, 3'b010, 0, 3'b000, 0, 3'b010, 2'd1, 1, 1);
      step("rg_c1",       0, 0, 3'b010, 0, 3'b000, 0, 3'b010, 2'd1, 1, 1);
      step("rg_reset",    0, 1, 3'b100, 0, 3'b000, 1, 3'b000, 2'd0, 0, 0);
      step("rg_after",    0, 0, 3'b100, 0, 3'b000, 0, 3'b100, 2'd2, 1, 0);
      step("rg_done",     0, 0, 3'b100, 0, 3'b000, 1, 3'b000, 2'd2, 1, 0);
      step("rg_idle",     0, 0, 3'b000, 0, 3'b000, 0, 3'b000, 2'd2, 0, 0);
      // rotating-priority instance
      step("rr_rst",      1, 1, 3'b111, 0, 3'b000, 0, 3'b000, 2'd0, 0, 0);
      step("rr_g0",       1, 0, 3'b111, 0, 3'b000, 0, 3'b001, 2'd0, 1, 0);
      step("rr_d0",       1, 0, 3'b111, 0, 3'b000, 1, 3'b000, 2'd0, 1, 0);
      step("rr_i0",       1, 0, 3'b111, 0, 3'b000, 0, 3'b000, 2'd0, 0, 0);
      step("rr_g1",       1, 0, 3'b111, 0, 3'b000, 0, 3'b010, 2'd1, 1, 0);
      step("rr_d1",       1, 0, 3'b111, 0, 3'b000, 1, 3'b000, 2'd1, 1, 0);
      step("rr_i1",       1, 0, 3'b111, 0, 3'b000, 0, 3'b000, 2'd1, 0, 0);
      step("rr_g2",       1, 0, 3'b111, 0, 3'b000, 0, 3'b100, 2'd2, 1, 0);
      step("rr_d2",       1, 0, 3'b111, 0, 3'b000, 1, 3'b000, 2'd2, 1, 0);
      step("rr_i2",       1, 0, 3'b111, 0, 3'b000, 0, 3'b000, 2'd2, 0, 0);
      step("rr_g0b",      1, 0, 3'b111, 0, 3'b000, 0, 3'b001, 2'd0, 1, 0);
      step("rr_d0b",      1, 0, 3'b111, 0, 3'b000, 1, 3'b000, 2'd0, 1, 0);
      step("rr_i0b",      1, 0, 3'b111, 0, 3'b000, 0, 3'b000, 2'd0, 0, 0);
      step("rr_g1b",      1, 0, 3'b111, 0, 3'b000, 0, 3'b010, 2'd1, 1, 0);
      step("rr_d1b",      1, 0, 3'b111, 1, 3'b111, 1, 3'b000, 2'd1, 1, 0);
      step("rr_rel",      1, 0, 3'b011, 0, 3'b000, 0, 3'b000, 2'd1, 0, 0);
      step("rr_wrap",     1, 0, 3'b011, 0, 3'b000, 0, 3'b001, 2'd0, 1, 0);
      step("rr_wrap_d",   1, 0, 3'b011, 0, 3'b000, 1, 3'b000, 2'd0, 1, 0);
      step("rr_end",      1, 0, 3'b000, 0, 3'b000, 0, 3'b000, 2'd0, 0, 0);

      for (int i = 0; i < 5 && exp_q.size() > 0; i++)
         @(negedge clk);
      #1;
      if (exp_q.size() > 0) begin
         n_fail++;
         $display("FAIL drain: %0d expected entries never compared, required 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
